sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word address width toward the SDRAM controller.
REQ-002 SHALL have parameter DATA_W, default 16, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter MAX_PEND, default 4, maximum outstanding reads (power of 2, ≥2).
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk_clk  input  1  system clock; all logic is rising-edge.
REQ-006 reset_reset  input  1  asynchronous, active-high reset.
REQ-007 rN_address (N=0,1)  input  ADDR_W  requester N word address.
REQ-008 rN_read / rN_write  input  1 each  requester N command; both high together is illegal and treated as read.
REQ-009 rN_writedata, rN_byteenable  input  DATA_W, DATA_W/8  requester N write payload.
REQ-010 rN_waitrequest  output  1  low for exactly one cycle when requester N's command is accepted.
REQ-011 rN_readdata, rN_readdatavalid  output  DATA_W, 1  requester N read return.
REQ-012 s_address, s_read, s_write, s_writedata, s_byteenable  output  as above  command to SDRAM controller.
REQ-013 s_waitrequest, s_readdata, s_readdatavalid  input  1, DATA_W, 1  SDRAM controller response.
REQ-014 tag_err  output  1  sticky: readdatavalid arrived with no outstanding read.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> ACK -> IDLE.
REQ-016 IDLE: eligible requesters are rN_read|rN_write, with reads ineligible while the tag FIFO is full; if any is eligible, latch winner's command into s_* registers, go to ISSUE next cycle.
REQ-017 ISSUE: s_read/s_write asserted, held stable until sampled with s_waitrequest low; then go to ACK.
REQ-018 Acceptance of a read in ISSUE SHALL push the winner ID into the tag FIFO in the same cycle.
REQ-019 ACK: s_read/s_write low; winner's rN_waitrequest low for this one cycle; return to IDLE; the loser's waitrequest stays high throughout.
REQ-020 Minimum latency: request seen in IDLE at cycle 0 -> s_* valid at cycle 1 -> rN_waitrequest low at cycle 2 (with s_waitrequest low at cycle 1).
REQ-021 Arbitration (default): round-robin; on simultaneous eligibility, grant the requester not granted last; a single eligible requester always wins.
REQ-022 s_readdatavalid SHALL pop the tag FIFO head and drive that requester's rN_readdatavalid in the same cycle (combinational); readdata is broadcast to both rN_readdata.
REQ-023 Push and pop in the same cycle SHALL leave the count unchanged; pop with empty FIFO is dropped and sets tag_err.
REQ-024 Read returns SHALL be routed in issue order regardless of FSM state.

Reset
REQ-025 On reset: FSM = IDLE, s_read = s_write = 0, s_address/s_writedata = 0, s_byteenable = 0, both rN_waitrequest = 1, rN_readdatavalid = 0, tag FIFO empty, last-grant = 1 (r0 wins first tie), tag_err = 0.
REQ-026 Reset mid-transaction SHALL abandon it; read data returning afterwards is dropped and flagged via tag_err.

Configuration
REQ-027 Macro SDRAM_ARB_PRIO_EN: if defined, r0 has strict priority over r1 (r1 granted only when r0 is ineligible); if undefined, round-robin per REQ-021.

Structure
REQ-028 Package sdram_arb_pkg SHALL hold the FSM state enum, requester ID type, and the NUM_REQ = 2 constant.
REQ-029 Tag FIFO SHALL be the sub-module sdram_arb_tag_fifo (depth MAX_PEND, width 1, push/pop/full/empty).

Verification
REQ-030 r0 read at 0x0000100, s_waitrequest low -> s_read at cycle 1, r0_waitrequest low at cycle 2 only; data 0xBEEF returned -> r0_readdatavalid, r0_readdata = 0xBEEF.
REQ-031 r0 and r1 writes held continuously, s_waitrequest low -> grants alternate r0,r1,r0,r1 (with SDRAM_ARB_PRIO_EN: r0 only).
REQ-032 s_waitrequest high for 5 cycles in ISSUE -> s_address/s_writedata stable for those cycles; r0_waitrequest stays high until the cycle after acceptance.
REQ-033 Issue 4 reads (r0,r1,r0,r1) with no return -> fifth read is stalled while r1 write is still granted; returns 0x1111..0x4444 route to r0,r1,r0,r1.
REQ-034 Push and pop in the same cycle at count 3 -> count stays 3; s_readdatavalid with FIFO empty -> tag_err = 1 and held until reset.
REQ-035 Reset asserted in ISSUE -> all outputs at REQ-025 values immediately (asynchronously); no acknowledge is issued afterwards.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter: FSM states, requester ID
// and the grant-selection helper used by the top level.
package sdram_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } arb_state_e;

  typedef logic [0:0] req_id_t;

  // Round-robin favours the requester not granted last; priority mode always favours r0.
  function automatic req_id_t pick_winner(input logic i_elig0, input logic i_elig1,
                                          input req_id_t i_last, input logic i_prio);
    req_id_t v_pick;
    if (i_elig0 && i_elig1) begin
      v_pick = i_prio ? 1'b0 : ~i_last;
    end else if (i_elig0) begin
      v_pick = 1'b0;
    end else begin
      v_pick = 1'b1;
    end
    return v_pick;
  endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Small FIFO of requester IDs for reads in flight; routes read returns in issue order.
// A push while full is only taken when a pop frees the slot in the same cycle.
module sdram_arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  req_id_t i_push_id,
  input  logic    i_pop,
  output req_id_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  req_id_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_push_id;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of an SDRAM controller; read returns routed via a tag FIFO.
// Define SDRAM_ARB_PRIO_EN for strict r0 priority; otherwise grants are round-robin.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   r0_address,
  input  logic                r0_read,
  input  logic                r0_write,
  input  logic [DATA_W-1:0]   r0_writedata,
  input  logic [DATA_W/8-1:0] r0_byteenable,
  output logic                r0_waitrequest,
  output logic [DATA_W-1:0]   r0_readdata,
  output logic                r0_readdatavalid,
  input  logic [ADDR_W-1:0]   r1_address,
  input  logic                r1_read,
  input  logic                r1_write,
  input  logic [DATA_W-1:0]   r1_writedata,
  input  logic [DATA_W/8-1:0] r1_byteenable,
  output logic                r1_waitrequest,
  output logic [DATA_W-1:0]   r1_readdata,
  output logic                r1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                tag_err
);

  localparam int BE_W = DATA_W / 8;
`ifdef SDRAM_ARB_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  arb_state_e        r_state;
  req_id_t           r_winner;
  req_id_t           r_last_grant;
  logic              r_s_read;
  logic              r_s_write;
  logic [ADDR_W-1:0] r_s_address;
  logic [DATA_W-1:0] r_s_writedata;
  logic [BE_W-1:0]   r_s_byteenable;
  logic              r_wait0;
  logic              r_wait1;
  logic              r_tag_err;

  logic              w_full;
  logic              w_empty;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_push;
  req_id_t           w_pick;
  req_id_t           w_head;

  // Read+write together counts as a read, so a full tag FIFO blocks it.
  assign w_elig0 = r0_read ? ~w_full : r0_write;
  assign w_elig1 = r1_read ? ~w_full : r1_write;
  assign w_pick  = pick_winner(w_elig0, w_elig1, r_last_grant, PRIO_EN);
  assign w_push  = (r_state == ST_ISSUE) & r_s_read & ~s_waitrequest;

  // Arbitration FSM; every controller-facing and acknowledge output is registered here.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state        <= ST_IDLE;
      r_winner       <= 1'b0;
      r_last_grant   <= 1'b1;
      r_s_read       <= 1'b0;
      r_s_write      <= 1'b0;
      r_s_address    <= '0;
      r_s_writedata  <= '0;
      r_s_byteenable <= '0;
      r_wait0        <= 1'b1;
      r_wait1        <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wait0 <= 1'b1;
          r_wait1 <= 1'b1;
          if (w_elig0 || w_elig1) begin
            r_winner       <= w_pick;
            r_last_grant   <= w_pick;
            r_s_address    <= w_pick[0] ? r1_address    : r0_address;
            r_s_writedata  <= w_pick[0] ? r1_writedata  : r0_writedata;
            r_s_byteenable <= w_pick[0] ? r1_byteenable : r0_byteenable;
            r_s_read       <= w_pick[0] ? r1_read : r0_read;
            r_s_write      <= w_pick[0] ? (r1_write & ~r1_read) : (r0_write & ~r0_read);
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!s_waitrequest) begin
            r_s_read  <= 1'b0;
            r_s_write <= 1'b0;
            r_wait0   <= r_winner[0];
            r_wait1   <= ~r_winner[0];
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_wait0 <= 1'b1;
          r_wait1 <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_s_read  <= 1'b0;
          r_s_write <= 1'b0;
          r_wait0   <= 1'b1;
          r_wait1   <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flag for read data arriving with nothing outstanding.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_tag_err <= 1'b0;
    end else if (s_readdatavalid && w_empty) begin
      r_tag_err <= 1'b1;
    end
  end

  sdram_arb_tag_fifo #(
    .DEPTH (MAX_PEND)
  ) u_tag_fifo (
    .i_clk     (clk_clk),
    .i_rst     (reset_reset),
    .i_push    (w_push),
    .i_push_id (r_winner),
    .i_pop     (s_readdatavalid),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign s_address        = r_s_address;
  assign s_read           = r_s_read;
  assign s_write          = r_s_write;
  assign s_writedata      = r_s_writedata;
  assign s_byteenable     = r_s_byteenable;
  assign r0_waitrequest   = r_wait0;
  assign r1_waitrequest   = r_wait1;
  assign tag_err          = r_tag_err;
  assign r0_readdata      = s_readdata;
  assign r1_readdata      = s_readdata;
  assign r0_readdatavalid = s_readdatavalid & ~w_empty & ~w_head[0];
  assign r1_readdatavalid = s_readdatavalid & ~w_empty &  w_head[0];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed boundary cases plus a randomized scoreboard run against a queue-based
// model of the arbiter and a behavioural SDRAM controller.
module tb_sdram_arbiter;

  localparam int ADDR_W   = 25;
  localparam int DATA_W   = 16;
  localparam int MAX_PEND = 4;
`ifdef SDRAM_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] r0_address, r1_address, s_address;
  logic r0_read, r0_write, r1_read, r1_write;
  logic [DATA_W-1:0] r0_writedata, r1_writedata, s_writedata;
  logic [1:0] r0_byteenable, r1_byteenable, s_byteenable;
  logic r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
  logic [DATA_W-1:0] r0_readdata, r1_readdata, s_readdata;
  logic s_read, s_write, s_waitrequest, s_readdatavalid, tag_err;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk), .reset_reset(rst),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
    .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
    .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .tag_err(tag_err)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic rd, input logic wr,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (id == 0) begin
      r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; r0_byteenable = 2'b11;
    end else begin
      r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; r1_byteenable = 2'b11;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    r0_byteenable = 2'b00; r1_byteenable = 2'b00;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0; s_readdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ack(input int id, input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (((id == 0) ? r0_waitrequest : r1_waitrequest) == 1'b0) got = 1'b1;
      tick();
    end
    chk(name, got, 1'b1);
  endtask

  task automatic ret(input logic [DATA_W-1:0] data, input logic exp_id, input string name);
    s_readdatavalid = 1'b1;
    s_readdata = data;
    @(negedge clk);
    chk(name, {r1_readdatavalid, r0_readdatavalid, (exp_id ? r1_readdata : r0_readdata)},
        {(exp_id ? 2'b10 : 2'b01), data});
    tick();
    s_readdatavalid = 1'b0;
  endtask

  // ---------------- random-phase model and scoreboard state ----------------
  typedef struct {logic id; logic [DATA_W-1:0] data;} ret_t;
  ret_t ret_q[$];
  logic out_q[$];
  logic mon_on = 1'b0;
  logic [1:0] exp_ack;
  logic hold_prev;
  logic [44:0] hold_val;
  logic m_id;
  ret_t m_e;
  int n_reads, n_rets;
  logic busy[2], ack_seen[2], cur_rd[2], cur_wr[2];
  logic [ADDR_W-1:0] cur_addr[2];
  logic [DATA_W-1:0] cur_wd[2];
  logic [1:0] cur_be[2];

  task automatic step(input logic issue_on, input logic drain);
    int sel;
    for (int id = 0; id < 2; id++) begin
      if (ack_seen[id]) begin busy[id] = 1'b0; ack_seen[id] = 1'b0; end
      if (!busy[id]) begin
        cur_rd[id] = 1'b0; cur_wr[id] = 1'b0;
        if (issue_on && $urandom_range(0, 3) != 0) begin
          sel = $urandom_range(0, 7);
          cur_rd[id]   = (sel <= 4) || (sel == 7);
          cur_wr[id]   = (sel >= 5);
          cur_addr[id] = {(id == 1) ? 1'b1 : 1'b0, 24'($urandom)};
          cur_wd[id]   = 16'($urandom);
          cur_be[id]   = 2'($urandom);
          busy[id]     = 1'b1;
        end
      end
    end
    r0_read = cur_rd[0]; r0_write = cur_wr[0]; r0_address = cur_addr[0];
    r0_writedata = cur_wd[0]; r0_byteenable = cur_be[0];
    r1_read = cur_rd[1]; r1_write = cur_wr[1]; r1_address = cur_addr[1];
    r1_writedata = cur_wd[1]; r1_byteenable = cur_be[1];
    s_waitrequest = ($urandom_range(0, 2) == 0);
    if (out_q.size() > 0 && (drain || $urandom_range(0, 5) == 0)) begin
      ret_t e;
      e.id = out_q.pop_front();
      e.data = 16'($urandom);
      ret_q.push_back(e);
      s_readdatavalid = 1'b1;
      s_readdata = e.data;
    end else begin
      s_readdatavalid = 1'b0;
    end
  endtask

  // Monitor: acknowledges, accepted commands, hold stability and read routing.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("ack", {~r1_waitrequest, ~r0_waitrequest}, exp_ack);
      if (!r0_waitrequest) ack_seen[0] = 1'b1;
      if (!r1_waitrequest) ack_seen[1] = 1'b1;
      exp_ack = 2'b00;
      if (hold_prev) chk("hold", {s_read, s_write, s_address, s_writedata, s_byteenable}, hold_val);
      hold_prev = (s_read | s_write) & s_waitrequest;
      hold_val = {s_read, s_write, s_address, s_writedata, s_byteenable};
      if ((s_read | s_write) && !s_waitrequest) begin
        m_id = s_address[ADDR_W-1];
        chk("cmd_busy", busy[m_id], 1'b1);
        chk("cmd", {s_read, s_write, s_address},
            {cur_rd[m_id], cur_wr[m_id] & ~cur_rd[m_id], cur_addr[m_id]});
        if (s_write) chk("wdata", {s_writedata, s_byteenable}, {cur_wd[m_id], cur_be[m_id]});
        exp_ack = m_id ? 2'b10 : 2'b01;
        if (s_read) begin
          chk("fifo_room", out_q.size() < MAX_PEND, 1'b1);
          out_q.push_back(m_id);
          n_reads++;
        end
      end
      if (s_readdatavalid) begin
        m_e = ret_q.pop_front();
        n_rets++;
        chk("route", {r1_readdatavalid, r0_readdatavalid, (m_e.id ? r1_readdata : r0_readdata)},
            {(m_e.id ? 2'b10 : 2'b01), m_e.data});
      end else if (r0_readdatavalid || r1_readdatavalid) begin
        chk("rdv_spurious", {r1_readdatavalid, r0_readdatavalid}, 2'b00);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] grants[4];
    int ng, n0, n1;
    logic done;

    // Reset values
    do_reset();
    @(negedge clk);
    chk("reset_vals", {s_read, s_write, s_address, s_writedata, s_byteenable, r0_waitrequest,
        r1_waitrequest, r0_readdatavalid, r1_readdatavalid, tag_err},
        {2'b00, 25'd0, 16'd0, 2'b00, 2'b11, 2'b00, 1'b0});

    // Minimum-latency read and data return
    tick();
    set_req(0, 1'b1, 1'b0, 25'h0000100, 16'h0);
    @(negedge clk);
    chk("lat_c0_sread", s_read, 1'b0);
    tick();
    @(negedge clk);
    chk("lat_c1", {s_read, s_address, r0_waitrequest}, {1'b1, 25'h0000100, 1'b1});
    tick();
    @(negedge clk);
    chk("lat_c2", {s_read, r0_waitrequest, r1_waitrequest}, 3'b001);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lat_c3_wait", r0_waitrequest, 1'b1);
    tick();
    ret(16'hBEEF, 1'b0, "ret_beef");

    // Continuous writes from both requesters
    do_reset();
    set_req(0, 1'b0, 1'b1, 25'h0000010, 16'hAAAA);
    set_req(1, 1'b0, 1'b1, 25'h1000020, 16'h5555);
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (!r0_waitrequest || !r1_waitrequest) begin
        grants[ng] = {~r1_waitrequest, ~r0_waitrequest};
        ng++;
      end
      tick();
    end
    chk("rr_count", ng, 4);
    for (int k = 0; k < ng; k++)
      chk("rr_grant", grants[k], PRIO ? 2'b01 : ((k % 2 == 0) ? 2'b01 : 2'b10));
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    // Command held while the controller stalls
    do_reset();
    s_waitrequest = 1'b1;
    set_req(0, 1'b0, 1'b1, 25'h00ABCDE, 16'h5A5A);
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold", {s_write, s_address, s_writedata, r0_waitrequest},
          {1'b1, 25'h00ABCDE, 16'h5A5A, 1'b1});
      tick();
    end
    s_waitrequest = 1'b0;
    @(negedge clk);
    chk("stall_accept_cycle", {s_write, r0_waitrequest}, 2'b11);
    tick();
    @(negedge clk);
    chk("stall_ack", r0_waitrequest, 1'b0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);

    // Tag FIFO full, simultaneous push/pop, ordered returns, empty pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(k % 2, 1'b1, 1'b0, 25'(k), 16'h0);
      wait_ack(k % 2, "fill_ack");
      set_req(k % 2, 1'b0, 1'b0, '0, '0);
    end
    set_req(0, 1'b1, 1'b0, 25'h0000055, 16'h0);
    set_req(1, 1'b0, 1'b1, 25'h1000066, 16'h1234);
    n0 = 0; n1 = 0;
    repeat (12) begin
      @(negedge clk);
      if (!r0_waitrequest) n0++;
      if (!r1_waitrequest) n1++;
      tick();
    end
    chk("full_stall_r0", n0, 0);
    chk("full_write_r1", n1 > 0, 1'b1);
    set_req(1, 1'b0, 1'b0, '0, '0);
    repeat (4) tick();
    s_waitrequest = 1'b1;
    ret(16'h1111, 1'b0, "ret_1111");
    tick();
    s_waitrequest = 1'b0;
    ret(16'h2222, 1'b1, "ret_2222_pushpop");
    @(negedge clk);
    chk("pushpop_ack", r0_waitrequest, 1'b0);
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b0, 25'h1000077, 16'h0);
    wait_ack(1, "read_after_pushpop");
    set_req(1, 1'b0, 1'b0, '0, '0);
    ret(16'h3333, 1'b0, "ret_3333");
    ret(16'h4444, 1'b1, "ret_4444");
    ret(16'h5555, 1'b0, "ret_5555");
    ret(16'h6666, 1'b1, "ret_6666");
    chk("tag_err_clear", tag_err, 1'b0);
    s_readdatavalid = 1'b1;
    @(negedge clk);
    chk("empty_pop_rdv", {r1_readdatavalid, r0_readdatavalid}, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("tag_err_set", tag_err, 1'b1);
    repeat (3) tick();
    chk("tag_err_sticky", tag_err, 1'b1);

    // Asynchronous reset in ISSUE
    do_reset();
    s_waitrequest = 1'b1;
    set_req(0, 1'b1, 1'b0, 25'h0000200, 16'h0);
    tick();
    @(negedge clk);
    chk("issue_before_rst", s_read, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_vals", {s_read, s_write, s_address, s_writedata, s_byteenable, r0_waitrequest,
        r1_waitrequest, r0_readdatavalid, r1_readdatavalid, tag_err},
        {2'b00, 25'd0, 16'd0, 2'b00, 2'b11, 2'b00, 1'b0});
    set_req(0, 1'b0, 1'b0, '0, '0);
    s_waitrequest = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = 0;
    repeat (6) begin
      @(negedge clk);
      if (!r0_waitrequest || !r1_waitrequest || s_read) n0++;
      tick();
    end
    chk("no_ack_after_rst", n0, 0);
    s_readdatavalid = 1'b1;
    @(negedge clk);
    chk("drop_after_rst", {r1_readdatavalid, r0_readdatavalid}, 2'b00);
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    chk("tag_err_after_rst", tag_err, 1'b1);

    // Randomized traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; ack_seen[i] = 1'b0; cur_rd[i] = 1'b0; cur_wr[i] = 1'b0;
      cur_addr[i] = '0; cur_wd[i] = '0; cur_be[i] = '0;
    end
    exp_ack = 2'b00; hold_prev = 1'b0; hold_val = '0; n_reads = 0; n_rets = 0;
    mon_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step(1'b1, 1'b0);
      tick();
    end
    done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      step(1'b0, 1'b1);
      tick();
      done = !busy[0] && !busy[1] && (out_q.size() == 0);
    end
    s_readdatavalid = 1'b0;
    chk("drain", done, 1'b1);
    repeat (3) tick();
    mon_on = 1'b0;
    chk("rand_ret_count", n_rets, n_reads);
    chk("rand_reads_seen", n_reads > 50, 1'b1);
    chk("rand_tag_err", tag_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
